i2c_target_frontend: RTL and testbench

//  I2C target (slave) protocol engine that drives the PID gain register file's access port.

---
 rtl/i2c_pkg.sv | 32 +++
 rtl/i2c_target_frontend_sync.sv | 32 +++
 rtl/i2c_target_frontend.sv | 199 +++++++++++++++++++
 tb/tb_i2c_target_frontend.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target front end.
// FSM state encoding, PID gain register map, default device address.
package i2c_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_PTR,
    S_PTR_ACK,
    S_WDATA,
    S_WDATA_ACK,
    S_RDATA,
    S_RDATA_ACK,
    S_WAIT_STOP
  } state_e;

  localparam logic [7:0] ADDR_K_P = 8'h20;
  localparam logic [7:0] ADDR_K_I = 8'h21;
  localparam logic [7:0] ADDR_K_D = 8'h22;

  localparam logic [6:0] DEFAULT_TARGET_ADDR = 7'h48;

  // Device address lives in byte[7:1]; byte[0] is R/W.
  function automatic logic addr_match(
    input logic [7:0] b,
    input logic [6:0] target
  );
    return b[7:1] == target;
  endfunction

endpackage

// File: rtl/i2c_target_frontend_sync.sv
// Pin synchronizer with edge pulses for one bus line.
// Ports: clk, rst, d_i (raw pin), q_o (synced level), rise_o/fall_o (1-clk pulses).
module i2c_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // Reset to the idle-bus level so no edge is seen on release.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign q_o    = sync_q[STAGES-1];
  assign rise_o = q_o & ~prev_q;
  assign fall_o = ~q_o & prev_q;

endmodule

// File: rtl/i2c_target_frontend.sv
// I2C target engine driving the PID gain register file access port.
// Ports: clk, rst, scl_in/sda_in (raw pins), sda_oe (open-drain pull),
//   reg_addr/update_value/read_or_write/reg_strobe/read_value (reg port), busy.
module i2c_target_frontend
  import i2c_pkg::*;
#(
  parameter logic [6:0] TARGET_ADDR = DEFAULT_TARGET_ADDR,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] reg_addr,
  output logic [5:0] update_value,
  output logic       read_or_write,
  output logic       reg_strobe,
  input  logic [5:0] read_value,
  output logic       busy
);

  logic scl, scl_rise, scl_fall;
  logic sda, sda_rise, sda_fall;

  i2c_sync_edge #(.STAGES(SYNC_STAGES)) u_scl (
    .clk    (clk),
    .rst    (rst),
    .d_i    (scl_in),
    .q_o    (scl),
    .rise_o (scl_rise),
    .fall_o (scl_fall)
  );

  i2c_sync_edge #(.STAGES(SYNC_STAGES)) u_sda (
    .clk    (clk),
    .rst    (rst),
    .d_i    (sda_in),
    .q_o    (sda),
    .rise_o (sda_rise),
    .fall_o (sda_fall)
  );

  logic start, stop;
  assign start = sda_fall & scl;
  assign stop  = sda_rise & scl;

  state_e      state_q;
  logic [3:0]  bitcnt_q;
  logic [7:0]  shift_q;
  logic [7:0]  ptr_q;
  logic [5:0]  upd_q;
  logic        rw_q;
  logic        strobe_q;
  logic        sda_oe_q;
  logic        busy_q;
  logic        rd_q;
  logic [7:0]  byte_d;

  assign byte_d = {shift_q[6:0], sda};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      bitcnt_q <= '0;
      shift_q  <= '0;
      ptr_q    <= '0;
      upd_q    <= '0;
      rw_q     <= 1'b0;
      strobe_q <= 1'b0;
      sda_oe_q <= 1'b0;
      busy_q   <= 1'b0;
      rd_q     <= 1'b0;
    end else begin
      strobe_q <= 1'b0;
      // Cycle after an access: advance pointer, capture read data.
      if (strobe_q) begin
        ptr_q <= ptr_q + 8'd1;
        if (!rw_q) begin
          shift_q <= {2'b00, read_value};
        end
      end
      if (start) begin
        state_q  <= S_ADDR;
        bitcnt_q <= '0;
        sda_oe_q <= 1'b0;
      end else if (stop) begin
        state_q  <= S_IDLE;
        bitcnt_q <= '0;
        sda_oe_q <= 1'b0;
        busy_q   <= 1'b0;
      end else begin
        unique case (state_q)
          S_IDLE, S_WAIT_STOP: begin
          end
          S_ADDR: begin
            if (scl_rise) begin
              shift_q  <= byte_d;
              bitcnt_q <= bitcnt_q + 4'd1;
              if (bitcnt_q == 4'd7) begin
                bitcnt_q <= '0;
                if (addr_match(byte_d, TARGET_ADDR)) begin
                  state_q <= S_ADDR_ACK;
                  busy_q  <= 1'b1;
                  rd_q    <= byte_d[0];
                end else begin
                  state_q <= S_WAIT_STOP;
                end
              end
            end
          end
          S_PTR, S_WDATA: begin
            if (scl_rise) begin
              shift_q  <= byte_d;
              bitcnt_q <= bitcnt_q + 4'd1;
              if (bitcnt_q == 4'd7) begin
                bitcnt_q <= '0;
                if (state_q == S_PTR) begin
                  ptr_q   <= byte_d;
                  state_q <= S_PTR_ACK;
                end else begin
                  strobe_q <= 1'b1;
                  rw_q     <= 1'b1;
                  upd_q    <= byte_d[5:0];
                  state_q  <= S_WDATA_ACK;
                end
              end
            end
          end
          S_ADDR_ACK, S_PTR_ACK, S_WDATA_ACK: begin
            // Read address: fetch first byte while ACK is on the bus.
            if (scl_rise && sda_oe_q && rd_q
                && state_q == S_ADDR_ACK) begin
              strobe_q <= 1'b1;
              rw_q     <= 1'b0;
            end
            // First fall opens the ACK slot, second fall closes it.
            if (scl_fall) begin
              if (!sda_oe_q) begin
                sda_oe_q <= 1'b1;
              end else begin
                bitcnt_q <= '0;
                if (state_q == S_ADDR_ACK && rd_q) begin
                  state_q  <= S_RDATA;
                  sda_oe_q <= ~shift_q[7];
                end else begin
                  sda_oe_q <= 1'b0;
                  state_q  <= (state_q == S_ADDR_ACK)
                              ? S_PTR : S_WDATA;
                end
              end
            end
          end
          S_RDATA: begin
            if (scl_rise) begin
              bitcnt_q <= bitcnt_q + 4'd1;
            end
            if (scl_fall) begin
              if (bitcnt_q == 4'd8) begin
                sda_oe_q <= 1'b0;
                bitcnt_q <= '0;
                state_q  <= S_RDATA_ACK;
              end else begin
                shift_q  <= {shift_q[6:0], 1'b0};
                sda_oe_q <= ~shift_q[6];
              end
            end
          end
          S_RDATA_ACK: begin
            if (scl_rise) begin
              if (!sda) begin
                strobe_q <= 1'b1;
                rw_q     <= 1'b0;
              end else begin
                state_q <= S_WAIT_STOP;
              end
            end
            if (scl_fall) begin
              state_q  <= S_RDATA;
              bitcnt_q <= '0;
              sda_oe_q <= ~shift_q[7];
            end
          end
          default: begin
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign sda_oe        = sda_oe_q;
  assign reg_addr      = ptr_q;
  assign update_value  = upd_q;
  assign read_or_write = rw_q;
  assign reg_strobe    = strobe_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_i2c_target_frontend.sv
// Self-checking bench for i2c_target_frontend.
// Bit-banged controller, byte-level register model, random transactions.
module tb_i2c_target_frontend;

  localparam int Q = 6;
  localparam logic [6:0] TA = 7'h48;

  logic       clk = 1'b0;
  logic       rst;
  logic       scl_c, sda_c;
  logic       sda_oe;
  logic [7:0] reg_addr;
  logic [5:0] update_value;
  logic       read_or_write;
  logic       reg_strobe;
  logic [5:0] read_value;
  logic       busy;
  logic       bus_sda;
  logic       rf_load;

  always #5 clk = ~clk;

  assign bus_sda = sda_c & ~sda_oe;

  i2c_target_frontend dut (
    .clk           (clk),
    .rst           (rst),
    .scl_in        (scl_c),
    .sda_in        (bus_sda),
    .sda_oe        (sda_oe),
    .reg_addr      (reg_addr),
    .update_value  (update_value),
    .read_or_write (read_or_write),
    .reg_strobe    (reg_strobe),
    .read_value    (read_value),
    .busy          (busy)
  );

  // Register file stand-in and access monitor.
  logic [5:0]  rf [256];
  logic [14:0] got [1024];
  int          got_n = 0;
  int          oe_cnt = 0;

  assign read_value = rf[reg_addr];

  always @(negedge clk) begin
    if (rf_load) begin
      for (int i = 0; i < 256; i++) rf[i] = i[5:0] ^ 6'h08;
    end else if (reg_strobe && read_or_write) begin
      rf[reg_addr] = update_value;
    end
    if (reg_strobe) begin
      got[got_n] = {read_or_write, reg_addr,
                    read_or_write ? update_value : read_value};
      got_n = got_n + 1;
    end
    if (sda_oe) oe_cnt = oe_cnt + 1;
  end

  // Reference model.
  logic [5:0]  mem [256];
  logic [7:0]  ptr;
  logic [14:0] expq [$];
  int          got_base = 0;
  int          n_chk = 0;
  int          n_err = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic q();
    repeat (Q) @(posedge clk);
  endtask

  task automatic clock_bit(input logic b, output logic r);
    sda_c = b;  q();
    scl_c = 1'b1; q();
    r = bus_sda; q();
    scl_c = 1'b0; q();
  endtask

  task automatic i2c_start();
    sda_c = 1'b1; q();
    scl_c = 1'b1; q();
    sda_c = 1'b0; q();
    scl_c = 1'b0; q();
  endtask

  task automatic i2c_stop();
    sda_c = 1'b0; q();
    scl_c = 1'b1; q();
    sda_c = 1'b1; q();
    q();
  endtask

  task automatic wbyte(input logic [7:0] b, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) clock_bit(b[i], r);
    clock_bit(1'b1, r);
    ack = ~r;
  endtask

  task automatic rbyte(input logic nack, output logic [7:0] b);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b1, r);
      b[i] = r;
    end
    clock_bit(nack, r);
  endtask

  task automatic m_write(input logic [7:0] d);
    expq.push_back({1'b1, ptr, d[5:0]});
    mem[ptr] = d[5:0];
    ptr = ptr + 8'd1;
  endtask

  task automatic m_read(output logic [7:0] d);
    expq.push_back({1'b0, ptr, mem[ptr]});
    d = {2'b00, mem[ptr]};
    ptr = ptr + 8'd1;
  endtask

  task automatic check_txn(input string tag);
    int n;
    n = got_n - got_base;
    chk({tag, "_nstrobe"}, n, expq.size());
    for (int i = 0; i < n && i < expq.size(); i++)
      chk({tag, "_access"}, got[got_base + i], expq[i]);
    chk({tag, "_reg_addr"}, reg_addr, ptr);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_sda_oe"}, sda_oe, 0);
    got_base = got_n;
    expq.delete();
  endtask

  // Write: address, pointer, n data bytes, STOP.
  task automatic wr_txn(input logic [7:0] p, input int n,
                        input logic [7:0] d0, input bit rnd);
    logic ack;
    logic [7:0] d;
    i2c_start();
    wbyte({TA, 1'b0}, ack);
    chk("wr_addr_ack", ack, 1);
    chk("wr_busy", busy, 1);
    wbyte(p, ack);
    chk("wr_ptr_ack", ack, 1);
    ptr = p;
    for (int i = 0; i < n; i++) begin
      d = (rnd || i > 0) ? 8'($urandom) : d0;
      wbyte(d, ack);
      chk("wr_data_ack", ack, 1);
      m_write(d);
    end
    i2c_stop();
    check_txn("wr");
  endtask

  // Read n bytes, optionally setting the pointer via repeated START.
  task automatic rd_txn(input bit set_p, input logic [7:0] p,
                        input int n);
    logic ack;
    logic [7:0] b, e;
    i2c_start();
    if (set_p) begin
      wbyte({TA, 1'b0}, ack);
      chk("rd_waddr_ack", ack, 1);
      wbyte(p, ack);
      chk("rd_ptr_ack", ack, 1);
      ptr = p;
      i2c_start();
    end
    wbyte({TA, 1'b1}, ack);
    chk("rd_addr_ack", ack, 1);
    for (int i = 0; i < n; i++) begin
      m_read(e);
      rbyte(i == n - 1, b);
      chk("rd_data", b, e);
    end
    i2c_stop();
    check_txn("rd");
  endtask

  task automatic bad_txn(input logic [6:0] a);
    logic ack;
    int oe0;
    oe0 = oe_cnt;
    i2c_start();
    wbyte({a, 1'b0}, ack);
    chk("bad_addr_nack", ack, 0);
    chk("bad_busy", busy, 0);
    wbyte(8'h21, ack);
    chk("bad_ptr_nack", ack, 0);
    wbyte(8'h15, ack);
    i2c_stop();
    chk("bad_oe_never", oe_cnt - oe0, 0);
    check_txn("bad");
  endtask

  initial begin
    logic ack, r;
    logic [6:0] ba;
    int oe0, kind;
    scl_c = 1'b1;
    sda_c = 1'b1;
    rst = 1'b1;
    rf_load = 1'b1;
    for (int i = 0; i < 256; i++) mem[i] = i[5:0] ^ 6'h08;
    ptr = 8'h00;
    repeat (4) @(posedge clk);
    rf_load = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_sda_oe", sda_oe, 0);
    chk("rst_reg_addr", reg_addr, 0);
    chk("rst_update", update_value, 0);
    chk("rst_rw", read_or_write, 0);
    chk("rst_strobe", reg_strobe, 0);
    chk("rst_busy", busy, 0);

    wr_txn(8'h20, 1, 8'h08, 1'b0);
    chk("t1_update", update_value, 6'h08);
    chk("t1_rw", read_or_write, 1);
    bad_txn(7'h49);
    rd_txn(1'b1, 8'h22, 1);
    wr_txn(8'h21, 2, 8'h10, 1'b0);
    wr_txn(8'h20, 1, 8'hC7, 1'b0);
    chk("c7_update", update_value, 6'h07);
    wr_txn(8'hFE, 3, 8'h3F, 1'b0);
    rd_txn(1'b1, 8'hFF, 2);

    // STOP after 4 bits of a data byte: no access.
    i2c_start();
    wbyte({TA, 1'b0}, ack);
    wbyte(8'h21, ack);
    ptr = 8'h21;
    for (int i = 0; i < 4; i++) clock_bit(1'b1, r);
    i2c_stop();
    check_txn("partial");

    // Reset in the middle of an address byte after Sr.
    i2c_start();
    wbyte({TA, 1'b0}, ack);
    wbyte(8'h22, ack);
    i2c_start();
    clock_bit(1'b1, r);
    clock_bit(1'b0, r);
    clock_bit(1'b0, r);
    clock_bit(1'b1, r);
    chk("pre_rst_busy", busy, 1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_reg_addr", reg_addr, 0);
    chk("mid_rst_sda_oe", sda_oe, 0);
    chk("mid_rst_strobe", reg_strobe, 0);
    @(negedge clk);
    rst = 1'b0;
    ptr = 8'h00;
    oe0 = oe_cnt;
    for (int i = 3; i >= 0; i--) clock_bit(1'b0, r);
    clock_bit(1'b1, r);
    wbyte(8'h20, ack);
    wbyte(8'h05, ack);
    chk("post_rst_oe", oe_cnt - oe0, 0);
    i2c_stop();
    check_txn("post_rst");

    for (int t = 0; t < 24; t++) begin
      kind = $urandom_range(0, 4);
      case (kind)
        0, 1: wr_txn(8'($urandom_range(8'h1E, 8'h24)),
                     $urandom_range(0, 3), 8'h00, 1'b1);
        2: rd_txn(1'b1, 8'($urandom), $urandom_range(1, 3));
        3: rd_txn(1'b0, 8'h00, $urandom_range(1, 2));
        default: begin
          ba = 7'($urandom);
          if (ba == TA) ba = 7'h00;
          bad_txn(ba);
        end
      endcase
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
